// File: rtl/ex_mem_buf.sv
// ex_mem_buf: elastic EX->MEM buffer with 2-entry skid, flush and halt draining
module ex_mem_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_aluOut,
  input  logic [15:0] ex_wrData,
  input  logic [15:0] ex_adderSrc,
  input  logic [15:0] ex_pc,
  input  logic        ex_brchCnd,
  input  logic        ex_alujmp,
  input  logic        ex_memEn,
  input  logic        ex_memWr,
  input  logic        ex_regWrEn,
  input  logic        ex_halt,
  input  logic [2:0]  ex_wrReg,
  input  logic        flush,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [15:0] mem_aluOut,
  output logic [15:0] mem_wrData,
  output logic [15:0] mem_adderSrc,
  output logic [15:0] mem_pc,
  output logic        mem_brchCnd,
  output logic        mem_alujmp,
  output logic        mem_memEn,
  output logic        mem_memWr,
  output logic        mem_regWrEn,
  output logic        mem_halt,
  output logic [2:0]  mem_wrReg,
  output logic        halted
);
  typedef struct packed {
    logic [15:0] alu_out;
    logic [15:0] wr_data;
    logic [15:0] adder_src;
    logic [15:0] pc;
    logic        brch_cnd;
    logic        alujmp;
    logic        mem_en;
    logic        mem_wr;
    logic        reg_wr_en;
    logic        halt;
    logic [2:0]  wr_reg;
  } ent_t;
  ent_t m, s, d;
  logic m_v, s_v, halt_pend, halt_done, acc, del;
  assign d = {ex_aluOut, ex_wrData, ex_adderSrc, ex_pc, ex_brchCnd, ex_alujmp,
              ex_memEn, ex_memWr, ex_regWrEn, ex_halt, ex_wrReg};
  assign ex_ready = !s_v && !halt_pend && !halt_done;
  assign acc = ex_valid && ex_ready && !flush;
  assign del = m_v && mem_ready && !flush;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_v       <= 1'b0;
      s_v       <= 1'b0;
      halt_pend <= 1'b0;
      halt_done <= 1'b0;
      m         <= '0;
      s         <= '0;
    end else if (flush) begin
      m_v       <= 1'b0;
      s_v       <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      // main is free to take the input when empty or draining with no skid backlog
      if (!m_v || (del && !s_v)) begin
        m_v <= acc;
        if (acc) m <= d;
      end else if (del) begin
        m   <= s;
        s_v <= 1'b0;
      end else if (acc) begin
        s   <= d;
        s_v <= 1'b1;
      end
      if (acc && ex_halt) halt_pend <= 1'b1;
      if (del && m.halt) begin
        halt_pend <= 1'b0;
        halt_done <= 1'b1;
      end
    end
  assign mem_valid    = m_v;
  assign mem_aluOut   = m.alu_out;
  assign mem_wrData   = m.wr_data;
  assign mem_adderSrc = m.adder_src;
  assign mem_pc       = m.pc;
  assign mem_wrReg    = m.wr_reg;
  assign mem_brchCnd  = m_v && m.brch_cnd;
  assign mem_alujmp   = m_v && m.alujmp;
  assign mem_memEn    = m_v && m.mem_en;
  assign mem_memWr    = m_v && m.mem_wr;
  assign mem_regWrEn  = m_v && m.reg_wr_en;
  assign mem_halt     = m_v && m.halt;
  assign halted       = halt_done;
  a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst) !(s_v && !m_v));
endmodule

// File: tb/tb_ex_mem_buf.sv
// tb_ex_mem_buf: directed scenarios plus random traffic against a queue-based model
module tb_ex_mem_buf;
  typedef struct packed {
    logic [15:0] alu, wd, adder, pc;
    logic brch, aj, men, mwr, rwe, halt;
    logic [2:0] wr;
  } ent_t;
  logic clk = 0, rst = 0, ex_valid = 0, flush = 0, mem_ready = 0;
  logic ex_ready, mem_valid, halted;
  logic [15:0] mem_aluOut, mem_wrData, mem_adderSrc, mem_pc;
  logic mem_brchCnd, mem_alujmp, mem_memEn, mem_memWr, mem_regWrEn, mem_halt;
  logic [2:0] mem_wrReg;
  ent_t in = '0;
  ent_t act;
  ent_t q[$];
  bit m_pend, m_done;
  int nvec = 0, nerr = 0;
  ex_mem_buf dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluOut(in.alu), .ex_wrData(in.wd), .ex_adderSrc(in.adder), .ex_pc(in.pc),
    .ex_brchCnd(in.brch), .ex_alujmp(in.aj), .ex_memEn(in.men), .ex_memWr(in.mwr),
    .ex_regWrEn(in.rwe), .ex_halt(in.halt), .ex_wrReg(in.wr), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_aluOut(mem_aluOut),
    .mem_wrData(mem_wrData), .mem_adderSrc(mem_adderSrc), .mem_pc(mem_pc),
    .mem_brchCnd(mem_brchCnd), .mem_alujmp(mem_alujmp), .mem_memEn(mem_memEn),
    .mem_memWr(mem_memWr), .mem_regWrEn(mem_regWrEn), .mem_halt(mem_halt),
    .mem_wrReg(mem_wrReg), .halted(halted)
  );
  assign act = {mem_aluOut, mem_wrData, mem_adderSrc, mem_pc, mem_brchCnd, mem_alujmp,
                mem_memEn, mem_memWr, mem_regWrEn, mem_halt, mem_wrReg};
  always #5 clk = ~clk;

  function automatic ent_t rnd(input logic [15:0] a, input logic h);
    ent_t e;
    e.alu = a;
    e.wd = 16'($urandom);
    e.adder = 16'($urandom);
    e.pc = 16'($urandom);
    {e.brch, e.aj, e.men, e.mwr, e.rwe} = 5'($urandom);
    e.halt = h;
    e.wr = 3'($urandom);
    return e;
  endfunction

  function automatic bit model_ready();
    return q.size() < 2 && !m_pend && !m_done;
  endfunction

  // one clock edge; the model sees the same pre-edge inputs as the DUT
  task automatic tick();
    bit acc, del;
    ent_t x, y;
    x = in;
    acc = ex_valid && model_ready() && !flush;
    del = q.size() > 0 && mem_ready && !flush;
    @(posedge clk);
    if (flush) begin
      q.delete();
      m_pend = 0;
    end else begin
      if (del) begin
        y = q.pop_front();
        if (y.halt) begin
          m_pend = 0;
          m_done = 1;
        end
      end
      if (acc) begin
        q.push_back(x);
        if (x.halt) m_pend = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    ex_valid = 0;
    flush = 0;
    mem_ready = 0;
    @(posedge clk);
    #1;
    rst = 1;
    q.delete();
    m_pend = 0;
    m_done = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    #2;
    nvec++;
    if (ex_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready_in_reset got=%b exp=1", ex_ready); end
    nvec++;
    if ({mem_valid, halted, mem_halt, mem_aluOut} !== '0) begin
      nerr++; $display("FAIL reset_outputs got=%b/%b/%b/%h exp=0", mem_valid, halted, mem_halt, mem_aluOut);
    end
    do_reset();
    nvec++;
    if ({mem_valid, halted, ex_ready} !== 3'b001) begin
      nerr++; $display("FAIL reset_release got v/h/r=%b%b%b exp=001", mem_valid, halted, ex_ready);
    end
  endtask

  task automatic test_stream();
    logic [15:0] vals [3] = '{16'h0010, 16'h0020, 16'h0030};
    do_reset();
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1;
      in = rnd(vals[i], 1'b0);
      nvec++;
      if (ex_ready !== 1'b1) begin nerr++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, ex_ready); end
      tick();
      nvec++;
      if (mem_valid !== 1'b1 || mem_aluOut !== vals[i]) begin
        nerr++; $display("FAIL stream_out[%0d] got v=%b alu=%h exp v=1 alu=%h", i, mem_valid, mem_aluOut, vals[i]);
      end
    end
    ex_valid = 0;
    tick();
    nvec++;
    if (mem_valid !== 1'b0) begin nerr++; $display("FAIL stream_drain got=%b exp=0", mem_valid); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    ex_valid = 1;
    in = rnd(16'h1111, 1'b0);
    tick();
    in = rnd(16'h2222, 1'b0);
    tick();
    ex_valid = 0;
    nvec++;
    if (mem_aluOut !== 16'h1111 || ex_ready !== 1'b0 || mem_valid !== 1'b1) begin
      nerr++; $display("FAIL bp_full got alu=%h rdy=%b v=%b exp alu=1111 rdy=0 v=1", mem_aluOut, ex_ready, mem_valid);
    end
    mem_ready = 1;
    tick();
    nvec++;
    if (mem_aluOut !== 16'h2222 || mem_valid !== 1'b1 || ex_ready !== 1'b1) begin
      nerr++; $display("FAIL bp_shift got alu=%h v=%b rdy=%b exp alu=2222 v=1 rdy=1", mem_aluOut, mem_valid, ex_ready);
    end
    tick();
    nvec++;
    if (mem_valid !== 1'b0) begin nerr++; $display("FAIL bp_empty got=%b exp=0", mem_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    ex_valid = 1;
    in = rnd(16'hA001, 1'b0);
    tick();
    in = rnd(16'hA002, 1'b0);
    tick();
    in = rnd(16'h3333, 1'b0);
    flush = 1;
    mem_ready = 1;
    tick();
    flush = 0;
    ex_valid = 0;
    nvec++;
    if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin
      nerr++; $display("FAIL flush_clear got v=%b rdy=%b exp v=0 rdy=1", mem_valid, ex_ready);
    end
    tick();
    nvec++;
    if (mem_valid !== 1'b0) begin nerr++; $display("FAIL flush_skid_empty got v=%b exp=0", mem_valid); end
  endtask

  task automatic test_halt();
    int cnt = 0;
    do_reset();
    ex_valid = 1;
    in = rnd(16'h4444, 1'b1);
    tick();
    nvec++;
    if (ex_ready !== 1'b0) begin nerr++; $display("FAIL halt_blocks got=%b exp=0", ex_ready); end
    in = rnd(16'h5555, 1'b0);
    tick();
    nvec++;
    if (mem_aluOut !== 16'h4444 || mem_halt !== 1'b1 || halted !== 1'b0) begin
      nerr++; $display("FAIL halt_held got alu=%h mh=%b h=%b exp alu=4444 mh=1 h=0", mem_aluOut, mem_halt, halted);
    end
    mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (mem_halt && mem_valid) cnt++;
      tick();
    end
    nvec++;
    if (cnt !== 1) begin nerr++; $display("FAIL halt_once got=%0d exp=1", cnt); end
    nvec++;
    if (halted !== 1'b1 || mem_valid !== 1'b0 || ex_ready !== 1'b0) begin
      nerr++; $display("FAIL halt_done got h=%b v=%b rdy=%b exp h=1 v=0 rdy=0", halted, mem_valid, ex_ready);
    end
    flush = 1;
    tick();
    flush = 0;
    nvec++;
    if (halted !== 1'b1) begin nerr++; $display("FAIL halt_sticky got=%b exp=1", halted); end
  endtask

  task automatic test_flushed_halt();
    do_reset();
    ex_valid = 1;
    in = rnd(16'h6666, 1'b1);
    tick();
    ex_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    nvec++;
    if (halted !== 1'b0 || ex_ready !== 1'b1 || mem_valid !== 1'b0) begin
      nerr++; $display("FAIL flushed_halt got h=%b rdy=%b v=%b exp h=0 rdy=1 v=0", halted, ex_ready, mem_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_valid = 1;
    in = rnd(16'h7777, 1'b0);
    in.brch = 1;
    tick();
    in = rnd(16'h8888, 1'b1);
    tick();
    ex_valid = 0;
    #2;
    rst = 0;
    #1;
    nvec++;
    if ({mem_valid, mem_aluOut, mem_wrData, mem_pc, mem_brchCnd, mem_halt, mem_wrReg, halted} !== '0) begin
      nerr++; $display("FAIL async_reset_entries got v=%b alu=%h brch=%b h=%b exp 0", mem_valid, mem_aluOut, mem_brchCnd, halted);
    end
    rst = 1;
    q.delete();
    m_pend = 0;
    m_done = 0;
    ex_valid = 1;
    mem_ready = 1;
    in = rnd(16'h9999, 1'b1);
    @(posedge clk);
    #1;
    ex_valid = 0;
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    nvec++;
    if (halted !== 1'b0 || mem_valid !== 1'b0) begin
      nerr++; $display("FAIL async_reset_halted got h=%b v=%b exp 0", halted, mem_valid);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        ex_valid = $urandom_range(0, 3) != 0;
        mem_ready = $urandom_range(0, 2) != 0;
        flush = $urandom_range(0, 15) == 0;
        in = rnd(16'($urandom), $urandom_range(0, 49) == 0);
        nvec++;
        if (ex_ready !== model_ready()) begin
          nerr++; $display("FAIL rnd_ready seg%0d cyc%0d got=%b exp=%b", seg, i, ex_ready, model_ready());
        end
        tick();
        nvec++;
        if (mem_valid !== (q.size() > 0) || halted !== m_done) begin
          nerr++; $display("FAIL rnd_state seg%0d cyc%0d got v=%b h=%b exp v=%b h=%b", seg, i, mem_valid, halted, q.size() > 0, m_done);
        end
        nvec++;
        if (q.size() > 0 && act !== q[0]) begin
          nerr++; $display("FAIL rnd_payload seg%0d cyc%0d got=%h exp=%h", seg, i, act, q[0]);
        end else if (q.size() == 0 && {mem_brchCnd, mem_alujmp, mem_memEn, mem_memWr, mem_regWrEn, mem_halt} !== '0) begin
          nerr++; $display("FAIL rnd_ctrl_gate seg%0d cyc%0d got=%b exp=0", seg, i,
                           {mem_brchCnd, mem_alujmp, mem_memEn, mem_memWr, mem_regWrEn, mem_halt});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_halt();
    test_flushed_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/ex_mem_buf.md
# ex_mem_buf

Elastic EX→MEM pipeline buffer between the execute stage and the memory stage. It captures one instruction's execute results and control bits, and presents them to the memory stage through a valid/ready handshake. A 2-entry skid buffer absorbs memory-stage back-pressure without a combinational ready path. It also handles branch-redirect flushes and halt draining, so halt reaches the memory stage exactly once and nothing younger follows it.

## Interface
- Parameters: none; datapath fixed at 16 bits, register specifier at 3 bits.
- Reset and clock: one clock; reset is asynchronous and active-low.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `ex_valid` input 1: execute stage presents an instruction.
- `ex_ready` output 1: buffer accepts this cycle; `= !skid_valid && !halt_pend && !halt_done`.
- `ex_aluOut` input 16: ALU result, used as memory address or jump target.
- `ex_wrData` input 16: store data.
- `ex_adderSrc` input 16: branch displacement.
- `ex_pc` input 16: PC+2 of the instruction.
- `ex_brchCnd`, `ex_alujmp`, `ex_memEn`, `ex_memWr`, `ex_regWrEn`, `ex_halt` input 1 each: control bits.
- `ex_wrReg` input 3: destination register.
- `flush` input 1: synchronous kill of all buffered, non-delivered entries.
- `mem_valid` output 1: main entry is valid.
- `mem_ready` input 1: memory stage consumes the main entry this cycle.
- `mem_aluOut`, `mem_wrData`, `mem_adderSrc`, `mem_pc` output 16 each: main-entry fields.
- `mem_brchCnd`, `mem_alujmp`, `mem_memEn`, `mem_memWr`, `mem_regWrEn`, `mem_halt` output 1 each: main-entry control bits, each gated by `mem_valid`.
- `mem_wrReg` output 3: main-entry destination register.
- `halted` output 1: sticky; a halt entry has been consumed.

## Operation
- **Storage:** two entries, main and skid, each holding all payload fields plus a valid bit. Outputs come straight from main flops; no input-to-output combinational path.
- **Events:**
  - accept = `ex_valid && ex_ready && !flush`.
  - deliver = `mem_valid && mem_ready && !flush`.
- **Per-edge update** (`flush` = 0):
  - main empty, accept: input loads into main.
  - main full, deliver, skid full: skid moves to main, skid clears. Accept is impossible here because `ex_ready` = 0.
  - main full, deliver, skid empty, accept: input loads into main.
  - main full, deliver, no accept: main clears.
  - main full, no deliver, accept: input loads into skid.
  - otherwise: hold.
- **Flush:**
  - Clears main and skid valid bits and clears `halt_pend`.
  - Concurrent `ex_valid` input is discarded; a concurrent `mem_ready` does not count as delivery.
  - `halted` / `halt_done` are unaffected by flush.
- **Halt:**
  - Accepting an entry with `ex_halt` = 1 sets `halt_pend`, which blocks further accepts.
  - Delivering an entry with `mem_halt` = 1 clears `halt_pend` and sets `halt_done`. `halt_done` drives `halted` and stays set until reset.
- **Payload don't-care:** payload flops need not be cleared when valid = 0. All control outputs read 0 whenever `mem_valid` = 0.
- **Occupancy:** 0, 1 (main only) or 2 (main + skid). Skid valid without main valid is illegal; assert never.

## Timing
- Reset (asynchronous assertion) drives all of the following to 0: `mem_valid`, skid valid, `halt_pend`, `halt_done`, `halted`, and every `mem_*` output. `ex_ready` = 1 while in reset and after release.
- Latency: an entry accepted at edge N is visible on `mem_*` after edge N when main was empty, or when main was full and delivered at the same edge.
- Throughput: one instruction per cycle with `mem_ready` held high.
- `ex_ready` depends only on registered state, never on `mem_ready` or `ex_valid`.
- A stall costs exactly one skid slot. After one cycle of `mem_ready` = 0 with input streaming, `ex_ready` drops the next cycle.
- `flush` has priority over every other event at the same edge.
- Reset asserted mid-operation discards all entries immediately.

## Test plan
- **Stream:** `mem_ready` = 1; push aluOut 0x0010, 0x0020, 0x0030 on consecutive cycles → each appears on `mem_aluOut` one cycle later, with `mem_valid` continuous and `ex_ready` always 1.
- **Back-pressure:** hold `mem_ready` = 0 while pushing A = 0x1111, then B = 0x2222.
  - Expect main = A, skid = B, `ex_ready` = 0.
  - Raise `mem_ready` → A delivered, B moves to main, `ex_ready` returns to 1 one cycle later. Order preserved, nothing dropped.
- **Flush with full buffer:** two entries buffered and `ex_valid` = 1 with `flush` = 1 → next cycle `mem_valid` = 0 and skid empty, the input is not captured, and `ex_ready` = 1.
- **Halt:** push a halt entry followed by a normal entry.
  - The normal entry must see `ex_ready` = 0.
  - Deliver the halt → `halted` = 1 and stays 1 through a later `flush`.
  - `mem_halt` pulses exactly once.
- **Flushed halt:** accept a halt, then `flush` before delivery → `halted` stays 0 and `ex_ready` returns to 1.
- **Async reset:** assert `rst` low between clock edges with two entries held → `mem_valid`, all `mem_*` outputs and `halted` go to 0 immediately, before the next edge.
